alu_operand_regs: RTL
=====================

ALU_OPERAND_REGS -- requirements
Module: alu_operand_regs

Interface
REQ-001 SHALL have parameter N, default 8, as the data width of all data ports and registers.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port bus_in  input  N  shared data bus value for register loads.
REQ-005 SHALL have port load_a  input  1  load register A from bus_in at the next rising edge.
REQ-006 SHALL have port load_b  input  1  load register B from bus_in at the next rising edge.
REQ-007 SHALL have port output_a  input  1  request to drive register A onto bus_out.
REQ-008 SHALL have port output_b  input  1  request to drive register B onto bus_out.
REQ-009 SHALL have port subtract_enable  input  1  operation select for flag capture: 0 = A+B, 1 = A-B.
REQ-010 SHALL have port load_flags  input  1  capture carry/zero flags at the next rising edge.
REQ-011 SHALL have port data_out_a  output  N  register A contents, to ALU operand A.
REQ-012 SHALL have port data_out_b  output  N  register B contents, to ALU operand B.
REQ-013 SHALL have port bus_out  output  N  value driven toward the bus.
REQ-014 SHALL have port bus_drive  output  1  high when bus_out carries valid data.
REQ-015 SHALL have port flag_carry  output  1  registered carry flag.
REQ-016 SHALL have port flag_zero  output  1  registered zero flag.
REQ-017 SHALL have port bus_conflict  output  1  sticky error: both output requests seen in one cycle.

Function
REQ-018 SHALL drive data_out_a and data_out_b continuously from registers A and B (no added latency).
REQ-019 SHALL, on a rising edge with load_a high, set A to bus_in; A holds otherwise.
REQ-020 SHALL, on a rising edge with load_b high, set B to bus_in; B holds otherwise; load_a and load_b together SHALL load both with the same value.
REQ-021 SHALL compute combinationally an (N+1)-bit result R = A + (B XOR {N{subtract_enable}}) + subtract_enable from current register values.
REQ-022 SHALL, on a rising edge with load_flags high, set flag_carry to R[N] and flag_zero to 1 iff R[N-1:0] == 0; flags hold otherwise.
REQ-023 SHALL treat flag_carry in subtract mode as "no borrow" (A >= B unsigned gives 1).
REQ-024 SHALL, when load_flags and load_a/load_b coincide, compute flags from pre-edge A and B values.
REQ-025 SHALL drive bus_out combinationally: A if output_a, else B if output_b, else all zeros.
REQ-026 SHALL drive bus_drive = output_a OR output_b combinationally.
REQ-027 SHALL set bus_conflict at a rising edge where output_a and output_b are both high; it SHALL remain set until reset.
REQ-028 SHALL let a register drive bus_out and load from bus_in in the same cycle; the load captures bus_in, bus_out shows the pre-edge value.

Reset
REQ-029 SHALL, while reset is high, immediately force A, B, flag_carry, flag_zero and bus_conflict to 0, independent of clk.
REQ-030 SHALL ignore load_a, load_b, load_flags on any edge where reset is high; combinational outputs follow the cleared registers.
REQ-031 SHALL resume normal operation on the first rising edge after reset deasserts.

Verification
REQ-032 Add: load A=0x0F, B=0xF0, subtract_enable=0, load_flags -> data_out_a=0x0F, data_out_b=0xF0, flag_carry=0, flag_zero=0.
REQ-033 Add wrap: A=0xFF, B=0x01, subtract_enable=0, load_flags -> flag_carry=1, flag_zero=1.
REQ-034 Subtract: A=0xFF, B=0x8F, subtract_enable=1, load_flags -> flag_carry=1, flag_zero=0; A=0x00, B=0x01 -> flag_carry=0, flag_zero=0.
REQ-035 Bus: A=0x3C, output_a=1 -> bus_out=0x3C, bus_drive=1; output_a=output_b=1 for one edge -> bus_out=A, bus_conflict=1 and still 1 after both drop.
REQ-036 Simultaneous: A=0x05, B=0x05, subtract_enable=1, load_a with bus_in=0x09 and load_flags same edge -> flag_zero=1, A=0x09.
REQ-037 Reset mid-operation: A=0xAA, flags set, bus_conflict=1, assert reset between edges -> all registers and flags 0 before the next clk edge; loads ignored while reset high.

Source files
------------

// File: rtl/alu_operand_regs.sv
// rtl/alu_operand_regs.sv - ALU operand registers A/B with flag capture and bus driver
// Holds two operands, latches add/subtract flags and flags any dual-drive on the bus.
module alu_operand_regs #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] bus_in,
  input  logic         load_a,
  input  logic         load_b,
  input  logic         output_a,
  input  logic         output_b,
  input  logic         subtract_enable,
  input  logic         load_flags,
  output logic [N-1:0] data_out_a,
  output logic [N-1:0] data_out_b,
  output logic [N-1:0] bus_out,
  output logic         bus_drive,
  output logic         flag_carry,
  output logic         flag_zero,
  output logic         bus_conflict
);

  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic         carry_q, carry_d;
  logic         zero_q, zero_d;
  logic         conflict_q, conflict_d;
  logic [N:0]   result;

  // Two's-complement subtract: invert B and inject the carry-in, so carry means "no borrow".
  assign result = {1'b0, a_q}
                + {1'b0, (b_q ^ {N{subtract_enable}})}
                + {{N{1'b0}}, subtract_enable};

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    conflict_d = conflict_q;
    if (load_a) a_d = bus_in;
    if (load_b) b_d = bus_in;
    if (load_flags) begin
      carry_d = result[N];
      zero_d  = (result[N-1:0] == '0);
    end
    if (output_a && output_b) conflict_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      conflict_q <= conflict_d;
    end
  end

  assign data_out_a   = a_q;
  assign data_out_b   = b_q;
  assign bus_out      = output_a ? a_q : (output_b ? b_q : '0);
  assign bus_drive    = output_a | output_b;
  assign flag_carry   = carry_q;
  assign flag_zero    = zero_q;
  assign bus_conflict = conflict_q;

endmodule
